clk_gen_ctrl: RTL

Synthesizable programmable clock and enable generator with a run controller. It produces a divided output clock from `clk`. Period, high time (duty) and a bounded LFSR-driven jitter on the low phase are all programmable. Configuration arrives over a valid/ready port and takes effect only at period boundaries, so the output never glitches. It sits beside the system clock as the sequencer that starts, stops and retunes derived clocks and strobes.

---
 rtl/clk_gen_pkg.sv | 28 ++
 rtl/clk_gen_ctrl_lfsr.sv | 26 ++
 rtl/clk_gen_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/clk_gen_pkg.sv
// Shared types, constants and config sanitisation for the programmable clock generator.
package clk_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Galois right-shift mask for x^16 + x^14 + x^13 + x^11
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [31:0] MIN_PERIOD = 32'd2;

  function automatic logic [31:0] sanitise_period(input logic [31:0] period);
    return (period < MIN_PERIOD) ? MIN_PERIOD : period;
  endfunction

  // High time is clamped against the already-clamped period so at least one low cycle remains.
  function automatic logic [31:0] sanitise_high(input logic [31:0] period, input logic [31:0] high);
    logic [31:0] p;
    logic [31:0] h;
    p = sanitise_period(period);
    h = (high == 32'd0) ? 32'd1 : high;
    if (h >= p) h = p - 32'd1;
    return h;
  endfunction

endpackage

// File: rtl/clk_gen_ctrl_lfsr.sv
// 16-bit Galois LFSR with synchronous seed load and a step enable; exposes its low bits.
module lfsr16_step
  import clk_gen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int          OW   = 4
) (
  input  logic          clk,
  input  logic          load,
  input  logic          step,
  output logic [OW-1:0] low_bits
);

  logic [15:0] state;

  always_ff @(posedge clk) begin
    if (load) begin
      state <= SEED;
    end else if (step) begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign low_bits = state[OW-1:0];

endmodule

// File: rtl/clk_gen_ctrl.sv
// Programmable divided-clock generator: period, duty and LFSR low-phase jitter,
// reconfigured only at period boundaries through a single-entry pending register.
module clk_gen_ctrl
  import clk_gen_pkg::*;
#(
  parameter int          CW        = 16,
  parameter int          JW        = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_period,
  input  logic [CW-1:0] cfg_high,
  input  logic [JW-1:0] cfg_jitter,
  input  logic          cfg_en,
  output logic          out_clk,
  output logic          out_rise,
  output logic          out_fall,
  output logic          active,
  output logic [CW-1:0] cur_low
);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] period_r;
  logic [CW-1:0] high_r;
  logic [JW-1:0] jitter_r;

  logic          pend_valid;
  logic          pend_en;
  logic [CW-1:0] pend_period;
  logic [CW-1:0] pend_high;
  logic [JW-1:0] pend_jitter;

  logic          handshake;
  logic [CW-1:0] san_period;
  logic [CW-1:0] san_high;
  logic [JW-1:0] lfsr_bits;
  logic [JW-1:0] jit;
  logic [CW:0]   low_sum;
  logic [CW-1:0] low_len;
  logic          lfsr_step;

  assign cfg_ready = !pend_valid;
  assign handshake = cfg_valid && !pend_valid;
  assign active    = (state != IDLE);

  assign san_period = CW'(sanitise_period(32'(cfg_period)));
  assign san_high   = CW'(sanitise_high(32'(cfg_period), 32'(cfg_high)));

  // Low phase = (period - high) + jitter, widened by one bit and saturated.
  assign jit       = lfsr_bits & jitter_r;
  assign low_sum   = {1'b0, period_r - high_r} + (CW+1)'(jit);
  assign low_len   = low_sum[CW] ? {CW{1'b1}} : low_sum[CW-1:0];
  assign lfsr_step = (state == HIGH) && (cnt == '0);

  lfsr16_step #(
    .SEED (LFSR_SEED),
    .OW   (JW)
  ) u_lfsr (
    .clk      (clk),
    .load     (rst),
    .step     (lfsr_step),
    .low_bits (lfsr_bits)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      period_r    <= '0;
      high_r      <= '0;
      jitter_r    <= '0;
      pend_valid  <= 1'b0;
      pend_en     <= 1'b0;
      pend_period <= '0;
      pend_high   <= '0;
      pend_jitter <= '0;
      out_clk     <= 1'b0;
      out_rise    <= 1'b0;
      out_fall    <= 1'b0;
      cur_low     <= '0;
    end else begin
      out_rise <= 1'b0;
      out_fall <= 1'b0;

      // While running, requests park in pending; idle requests are applied directly below.
      if (handshake && state != IDLE) begin
        pend_valid  <= 1'b1;
        pend_en     <= cfg_en;
        pend_period <= san_period;
        pend_high   <= san_high;
        pend_jitter <= cfg_jitter;
      end

      case (state)
        IDLE: begin
          out_clk <= 1'b0;
          if (pend_valid) begin
            pend_valid <= 1'b0;
            if (pend_en) begin
              period_r <= pend_period;
              high_r   <= pend_high;
              jitter_r <= pend_jitter;
              cnt      <= pend_high - CW'(1);
              state    <= HIGH;
              out_clk  <= 1'b1;
              out_rise <= 1'b1;
            end
          end else if (handshake && cfg_en) begin
            period_r <= san_period;
            high_r   <= san_high;
            jitter_r <= cfg_jitter;
            cnt      <= san_high - CW'(1);
            state    <= HIGH;
            out_clk  <= 1'b1;
            out_rise <= 1'b1;
          end
        end

        HIGH: begin
          if (cnt == '0) begin
            cnt      <= low_len - CW'(1);
            cur_low  <= low_len;
            state    <= LOW;
            out_clk  <= 1'b0;
            out_fall <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        LOW: begin
          if (cnt == '0) begin
            if (pend_valid) begin
              pend_valid <= 1'b0;
              if (pend_en) begin
                period_r <= pend_period;
                high_r   <= pend_high;
                jitter_r <= pend_jitter;
                cnt      <= pend_high - CW'(1);
                state    <= HIGH;
                out_clk  <= 1'b1;
                out_rise <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt      <= high_r - CW'(1);
              state    <= HIGH;
              out_clk  <= 1'b1;
              out_rise <= 1'b1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        default: begin
          state   <= IDLE;
          out_clk <= 1'b0;
        end
      endcase
    end
  end

endmodule
